// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module  : uart_rx_pkg
// Brief   : Shared UART line levels and receiver state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Brief   : Two-flop synchronizer for an asynchronous input that idles high.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Reset to the idle level so reset release cannot look like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= IDLE_BIT;
      sync_q <= IDLE_BIT;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : Oversampling UART receiver, 8N1-style framing with WIDTH data bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stb,
  input  logic             i_uart_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int BIDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WIDTH - 1);

  logic              rx_s;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;
  logic              ferr_q;

  uart_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_uart_rx),
    .o_q   (rx_s)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      // Pulses last one clock regardless of strobe spacing.
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (i_stb) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_s == START_BIT) begin
              state_q <= ST_START;
              cnt_q   <= '0;
            end
          end
          ST_START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q   <= '0;
              bidx_q  <= '0;
              state_q <= (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              shreg_q <= {rx_s, shreg_q[WIDTH-1:1]};
              if (bidx_q == BIDX_LAST) begin
                state_q <= ST_STOP;
              end else begin
                bidx_q <= bidx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (rx_s == STOP_BIT) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_BREAK;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_BREAK: begin
            // A held-low line must return high before a new start is accepted.
            if (rx_s == IDLE_BIT) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx (directed table plus random frames).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int WIDTH = 8;
  localparam int OS    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stb = 1'b0;
  logic             rx  = 1'b1;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ferr;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_div  = 2;
  int cyc      = 0;
  int v_cyc    = 0;
  int e_cyc    = 0;
  logic busy_seen = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [WIDTH-1:0] last_good = '0;

  uart_rx #(.WIDTH(WIDTH), .OVERSAMPLE(OS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stb       (stb),
    .i_uart_rx   (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    stb = ((cyc % stb_div) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Output monitor: counts pulse cycles and watches output invariants.
  initial forever begin
    @(negedge clk);
    if (valid === 1'b1) v_cyc = v_cyc + 1;
    if (ferr === 1'b1)  e_cyc = e_cyc + 1;
    if (busy === 1'b1)  busy_seen = 1'b1;
    if (valid === 1'b1 || ferr === 1'b1)
      check("valid_err_exclusive", {31'd0, valid & ferr}, 32'd0);
    if (rst === 1'b0 && data !== prev_data)
      check("data_changes_only_with_valid", {31'd0, valid}, 32'd1);
    prev_data = data;
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!stb) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop, input int hold_bits);
    rx = 1'b0;
    ticks(OS);
    for (int i = 0; i < WIDTH; i++) begin
      rx = d[i];
      ticks(OS);
    end
    rx = stop;
    ticks(OS);
    if (!stop) begin
      if (hold_bits > 0) ticks(hold_bits * OS);
      check("busy_held_in_break", {31'd0, busy}, 32'd1);
      rx = 1'b1;
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             stop;
    int               hold;
    int               gap;
    int               div;
    int               exp_v;
    int               exp_e;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, e0;

    vecs[0] = '{8'hA5, 1'b1, 0, 20, 2, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 3, 20, 2, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 0, 0,  1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 0, 20, 1, 1, 0, 8'hFF};
    vecs[4] = '{8'h01, 1'b1, 0, 10, 3, 1, 0, 8'h01};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr",  {31'd0, ferr}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    ticks(10);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_no_pulse", v_cyc + e_cyc, 32'd0);

    for (int k = 0; k < 5; k++) begin
      stb_div = vecs[k].div;
      v0 = v_cyc;
      e0 = e_cyc;
      send_frame(vecs[k].d, vecs[k].stop, vecs[k].hold);
      ticks(vecs[k].gap);
      check($sformatf("vec%0d_valid_cycles", k), v_cyc - v0, vecs[k].exp_v);
      check($sformatf("vec%0d_err_cycles", k), e_cyc - e0, vecs[k].exp_e);
      check($sformatf("vec%0d_data", k), {24'd0, data}, {24'd0, vecs[k].exp_data});
      check($sformatf("vec%0d_busy_after", k), {31'd0, busy}, 32'd0);
    end
    last_good = 8'h01;

    // Short low glitch must be rejected at the half-bit check.
    stb_div = 2;
    busy_seen = 1'b0;
    v0 = v_cyc;
    e0 = e_cyc;
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(20);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_no_pulse", (v_cyc - v0) + (e_cyc - e0), 32'd0);
    check("glitch_data", {24'd0, data}, {24'd0, last_good});

    // Reset in the middle of 0x81, then a clean 0x5A.
    v0 = v_cyc;
    e0 = e_cyc;
    rx = 1'b0;
    ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      ticks(OS);
    end
    rx = 1'b0;
    ticks(OS / 2);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    ticks(2 * OS);
    check("abort_no_pulse", (v_cyc - v0) + (e_cyc - e0), 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    v0 = v_cyc;
    send_frame(8'h5A, 1'b1, 0);
    ticks(20);
    check("after_rst_valid", v_cyc - v0, 32'd1);
    check("after_rst_data", {24'd0, data}, 32'h5A);
    last_good = 8'h5A;

    // Random frames against a word-level model: a good stop updates the word,
    // a bad stop reports an error and leaves the word alone.
    for (int k = 0; k < 24; k++) begin
      logic [WIDTH-1:0] d;
      logic stop;
      int hold, gap;
      d       = WIDTH'($urandom);
      stop    = ($urandom_range(0, 4) != 0);
      hold    = $urandom_range(0, 2);
      gap     = stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
      stb_div = $urandom_range(1, 3);
      v0 = v_cyc;
      e0 = e_cyc;
      send_frame(d, stop, hold);
      ticks(gap);
      if (stop) last_good = d;
      check($sformatf("rnd%0d_valid", k), v_cyc - v0, stop ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_err", k), e_cyc - e0, stop ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_data", k), {24'd0, data}, {24'd0, last_good});
      check($sformatf("rnd%0d_busy", k), {31'd0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
